// File: rtl/multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared definitions for the multicycle CPU control unit:
//   - state_t         : FSM state enumeration (also the debug 'state' output)
//   - OP_* / FUNC_JR  : instruction opcode and function-field constants
//   - ALU_* / SRCB_* / PCSRC_* : datapath select encodings
//   - ctrl_t          : bundle of the Moore datapath controls
//   - helpers         : wait-state test, opcode legality, per-state controls
// -----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_R_EX     = 4'd6,
        ST_R_WB     = 4'd7,
        ST_I_EX     = 4'd8,
        ST_I_WB     = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_JR       = 4'd12
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    // Function field that turns an R-type opcode into a register jump
    localparam logic [5:0] FUNC_JR = 6'b001000;

    // ALU operation classes
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_FUNC = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;

    // ALU B operand select
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_REG_A  = 2'b11;

    // Moore control bundle (everything except the FETCH ir/pc write strobes
    // and the two event pulses, which depend on live inputs)
    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_op;
    } ctrl_t;

    // States that wait on mem_ready and are guarded by the wait timer
    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

    function automatic logic is_legal_opcode(input logic [5:0] op);
        logic legal;
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J,
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: legal = 1'b1;
            default:                           legal = 1'b0;
        endcase
        return legal;
    endfunction

    // ALU class for the immediate-arithmetic group
    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        logic [2:0] aop;
        case (op)
            OP_ANDI: aop = ALU_AND;
            OP_ORI:  aop = ALU_OR;
            OP_SLTI: aop = ALU_SLT;
            default: aop = ALU_ADD;
        endcase
        return aop;
    endfunction

    // Moore controls for a given state. The opcode only matters in I_EX.
    function automatic ctrl_t moore_ctrl(input state_t s, input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
            end
            ST_DECODE: begin
                c.alu_src_b = SRCB_IMM_SHL;
            end
            ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            ST_R_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.alu_op    = ALU_FUNC;
            end
            ST_R_WB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
            end
            ST_I_EX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = imm_alu_op(op);
            end
            ST_I_WB: begin
                c.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_B;
                c.alu_op        = ALU_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_JUMP;
            end
            ST_JR: begin
                c.pc_write  = 1'b1;
                c.pc_source = PCSRC_REG_A;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Control image loaded by reset (the FETCH Moore values)
    localparam ctrl_t CTRL_RESET = moore_ctrl(ST_FETCH, OP_R);

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts consecutive cycles spent waiting for memory.
//   clk      in  : system clock
//   rst_n    in  : asynchronous active-low reset (count returns to 0)
//   clear    in  : return the count to 0 on the next edge (has priority)
//   inc      in  : add one on the next edge (saturates at LIMIT)
//   expired  out : count currently equals LIMIT
// -----------------------------------------------------------------------------
module mem_wait_timer #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (inc && (r_count != LIMIT_W)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == LIMIT_W);

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Control FSM for a classic multicycle MIPS-style datapath.
// Parameters:
//   MEM_TIMEOUT : max consecutive cycles spent waiting for mem_ready in a
//                 memory state before the instruction is abandoned
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   opcode, func          : instruction fields (valid from DECODE onward)
//   mem_ready             : memory finishes the current access this cycle
//   pc_write .. alu_src_a : single-bit datapath controls
//   alu_src_b, pc_source  : 2-bit operand / PC selects
//   alu_op                : 3-bit ALU operation class
//   illegal_op            : pulse while DECODE sees an unsupported opcode
//   mem_timeout           : pulse on the cycle the memory wait gives up
//   state                 : current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [2:0] alu_op,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    state_t r_state;
    ctrl_t  r_ctrl;

    state_t w_state_next;
    logic   w_in_wait;
    logic   w_expired;
    logic   w_stay_waiting;
    logic   w_timeout;
    logic   w_illegal;
    logic   w_in_fetch;

    // -------------------------------------------------------------------------
    // Wait timer: it counts only while we sit in a wait state without
    // mem_ready and before expiry. Any other cycle clears it, which gives a
    // zero count on every entry (including re-entry of FETCH after a timeout).
    // -------------------------------------------------------------------------
    assign w_in_wait      = is_wait_state(r_state);
    assign w_stay_waiting = w_in_wait && !mem_ready && !w_expired;
    assign w_timeout      = w_in_wait && !mem_ready && w_expired;

    mem_wait_timer #(
        .LIMIT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (!w_stay_waiting),
        .inc     (w_stay_waiting),
        .expired (w_expired)
    );

    // -------------------------------------------------------------------------
    // Next-state logic. mem_ready always wins over an expiring timer.
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_illegal    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (mem_ready) begin
                    w_state_next = ST_DECODE;
                end else begin
                    // Still FETCH either way; a timeout simply restarts it
                    w_state_next = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_R:                w_state_next = (func == FUNC_JR) ? ST_JR : ST_R_EX;
                    OP_LW, OP_SW:        w_state_next = ST_MEM_ADDR;
                    OP_BEQ:              w_state_next = ST_BRANCH;
                    OP_J:                w_state_next = ST_JUMP;
                    OP_ADDI, OP_ANDI,
                    OP_ORI, OP_SLTI:     w_state_next = ST_I_EX;
                    default: begin
                        w_state_next = ST_FETCH;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                w_state_next = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                if (mem_ready) begin
                    w_state_next = ST_MEM_WB;
                end else if (w_expired) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_MEM_WR: begin
                if (mem_ready || w_expired) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_R_EX:   w_state_next = ST_R_WB;
            ST_I_EX:   w_state_next = ST_I_WB;
            ST_MEM_WB,
            ST_R_WB,
            ST_I_WB,
            ST_BRANCH,
            ST_JUMP,
            ST_JR:     w_state_next = ST_FETCH;
            default:   w_state_next = ST_FETCH;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and Moore controls are registered together: the controls for the
    // state being entered are computed from w_state_next, so they become
    // visible in the same cycle as the state itself. The asynchronous reset
    // kills any write strobe immediately.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
            r_ctrl  <= CTRL_RESET;
        end else begin
            r_state <= w_state_next;
            r_ctrl  <= moore_ctrl(w_state_next, opcode);
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. FETCH is the single Mealy exception: the instruction register
    // and PC+4 update exactly when memory delivers the instruction.
    // -------------------------------------------------------------------------
    assign w_in_fetch    = (r_state == ST_FETCH);

    assign pc_write      = r_ctrl.pc_write || (w_in_fetch && mem_ready);
    assign ir_write      = w_in_fetch && mem_ready;
    assign pc_write_cond = r_ctrl.pc_write_cond;
    assign iord          = r_ctrl.iord;
    assign mem_read      = r_ctrl.mem_read;
    assign mem_write     = r_ctrl.mem_write;
    assign mem_to_reg    = r_ctrl.mem_to_reg;
    assign reg_write     = r_ctrl.reg_write;
    assign reg_dst       = r_ctrl.reg_dst;
    assign alu_src_a     = r_ctrl.alu_src_a;
    assign alu_src_b     = r_ctrl.alu_src_b;
    assign pc_source     = r_ctrl.pc_source;
    assign alu_op        = r_ctrl.alu_op;

    assign illegal_op    = (r_state == ST_DECODE) && w_illegal;
    assign mem_timeout   = w_timeout;
    assign state         = r_state;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 255, maximum consecutive cycles the block waits for mem_ready in any memory state.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  6  instruction opcode, valid from DECODE onward.
REQ-005 func  input  6  instruction function field, used only for JR detection.
REQ-006 mem_ready  input  1  memory completes the current access this cycle.
REQ-007 pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_write, reg_dst, alu_src_a  output  1 each  standard multicycle datapath controls.
REQ-008 alu_src_b  output  2  selects 00 B, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate.
REQ-009 pc_source  output  2  selects 00 ALU result, 01 ALUOut, 10 jump target, 11 register A.
REQ-010 alu_op  output  3  ALU operation class: 000 add, 001 sub, 010 decode func, 011 and, 100 or, 101 slt.
REQ-011 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-012 mem_timeout  output  1  one-cycle pulse when the memory wait limit expires.
REQ-013 state  output  4  current state encoding, for debug.

Function
REQ-014 States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EX, R_WB, I_EX, I_WB, BRANCH, JUMP, JR.
REQ-015 Outputs are Moore. The only exception is FETCH, where ir_write and pc_write equal mem_ready.
REQ-016 Any control not listed for a state is 0. alu_op, alu_src_b and pc_source default to 000/00/00.
REQ-017 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000. Transition to DECODE on mem_ready; otherwise stay.
REQ-018 DECODE: alu_src_a=0, alu_src_b=11, alu_op=000. Next state by opcode:
  - 000000 with func=001000 -> JR; other 000000 -> R_EX
  - 100011/101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000/001100/001101/001010 -> I_EX
  - anything else -> FETCH, with illegal_op=1 for that one cycle.
REQ-019 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=000. Next state is MEM_RD if opcode=100011, else MEM_WR.
REQ-020 MEM_RD: mem_read=1, iord=1. Transition to MEM_WB on mem_ready.
REQ-021 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Then FETCH.
REQ-022 MEM_WR: mem_write=1, iord=1. Transition to FETCH on mem_ready.
REQ-023 R_EX: alu_src_a=1, alu_src_b=00, alu_op=010. Then R_WB.
REQ-024 R_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Then FETCH.
REQ-025 I_EX: alu_src_a=1, alu_src_b=10. alu_op is 000 for ADDI, 011 for ANDI, 100 for ORI, 101 for SLTI. Then I_WB.
REQ-026 I_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Then FETCH.
REQ-027 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_source=01. Then FETCH.
REQ-028 JUMP: pc_write=1, pc_source=10. Then FETCH.
REQ-029 JR: pc_write=1, pc_source=11. Then FETCH.
REQ-030 Wait counter behaviour:
  - Clears on entry to FETCH, MEM_RD or MEM_WR.
  - Increments each cycle the block stays in one of those states with mem_ready=0.
  - When the counter equals MEM_TIMEOUT with mem_ready=0, the next state is FETCH and mem_timeout=1 for that cycle; no ir_write, pc_write or reg_write occurs.
REQ-031 mem_ready=1 in the same cycle as expiry takes priority: normal transition, no mem_timeout.
REQ-032 Cycle counts with zero memory wait: R/I-type 4, LW 5, SW 4, BEQ/J/JR 3.

Reset
REQ-033 When rst_n=0, the block asynchronously enters FETCH with the wait counter at 0. All registered outputs read 0, except the FETCH Moore values (mem_read=1, alu_src_b=01).
REQ-034 Reset asserted mid-instruction abandons the instruction; no write strobe is issued after rst_n falls.
REQ-035 After rst_n rises, the first rising clock edge begins a FETCH wait.

Structure
REQ-036 A shared package holds:
  - the state enumeration
  - opcode constants (R, LW, SW, BEQ, J, ADDI, ANDI, ORI, SLTI)
  - FUNC_JR
  - the alu_op, alu_src_b and pc_source encodings.
REQ-037 The memory wait counter is a sub-module, mem_wait_timer, with inputs clear and inc and output expired.

Verification
REQ-038 Reset then R-type add with mem_ready held at 1 -> state sequence FETCH, DECODE, R_EX, R_WB, FETCH; alu_op=010 in R_EX; reg_write=1, reg_dst=1 in R_WB.
REQ-039 LW with mem_ready low for 3 cycles in MEM_RD -> MEM_RD lasts 4 cycles with iord=1; then MEM_WB with reg_write=1, mem_to_reg=1; total 8 cycles.
REQ-040 Opcode 111111 in DECODE -> illegal_op pulses for 1 cycle; next state FETCH; no write strobes.
REQ-041 MEM_TIMEOUT=3, mem_ready held at 0 in MEM_WR -> mem_timeout pulses in the 4th MEM_WR cycle, next state FETCH; mem_ready=1 on that same cycle -> no pulse.
REQ-042 BEQ, J, and JR (opcode 000000, func 001000) -> pc_source 01, 10 and 11 respectively, each completing in 3 cycles.
REQ-043 rst_n dropped during I_WB -> reg_write deasserts immediately, without waiting for a clock edge; state reads FETCH.
